// File: rtl/spi_cmd_sequencer.sv
// APB command sequencer: turns one SPI command into back-to-back APB writes to the
// SPI master's registers, then tracks chip-select for completion or timeout.
module spi_cmd_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 1023
) (
   input  logic        pclk_i,
   input  logic        presetn_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_instr_i,
   input  logic [39:0] cmd_data_i,
   input  logic [2:0]  cmd_cnt_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        timeout_o,
   output logic [7:0]  paddr_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [7:0]  pwdata_o,
   input  logic        pready_i,
   input  logic        spi_cs_i
);

   // Command handshake: a command transfers on a rising edge where cmd_valid_i and
   // cmd_ready_o are both high; cmd_ready_o is high exactly when the FSM is idle.

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_WAIT_LOW,
      S_WAIT_HIGH
   } state_t;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t      state_q;
   logic [7:0]  instr_q;
   logic [39:0] data_q;
   logic [2:0]  cnt_q;
   logic [2:0]  idx_q;
   logic [15:0] tmo_q;

   logic [2:0]  cnt_clamped;
   logic        last_entry;
   logic        tmo_hit;

   assign cnt_clamped = (cmd_cnt_i > 3'd5) ? 3'd5 : cmd_cnt_i;
   assign last_entry  = (idx_q == cnt_q + 3'd2);
   assign tmo_hit     = (tmo_q == TMO_LAST);
   assign cmd_ready_o = (state_q == S_IDLE);

   // Entry idx of the write list as {address, data}: INSTR, BYTES_1..cnt, BYTES_CNT, DRIVE.
   function automatic logic [15:0] write_entry(input logic [2:0]  idx,
                                               input logic [2:0]  cnt,
                                               input logic [7:0]  instr,
                                               input logic [39:0] data);
      logic [7:0] b;
      case (idx)
         3'd1:    b = data[7:0];
         3'd2:    b = data[15:8];
         3'd3:    b = data[23:16];
         3'd4:    b = data[31:24];
         default: b = data[39:32];
      endcase
      if (idx == 3'd0)                 return {8'h00, instr};
      else if (idx <= cnt)             return {5'd0, idx, b};
      else if (idx == cnt + 3'd1)      return {8'h06, 5'd0, cnt};
      else                             return {8'h07, 8'hFF};
   endfunction

   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q   <= S_IDLE;
         instr_q   <= '0;
         data_q    <= '0;
         cnt_q     <= '0;
         idx_q     <= '0;
         tmo_q     <= '0;
         busy_o    <= 1'b0;
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         paddr_o   <= '0;
         pwdata_o  <= '0;
         psel_o    <= 1'b0;
         penable_o <= 1'b0;
         pwrite_o  <= 1'b0;
      end else begin
         done_o    <= 1'b0;
         timeout_o <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cmd_valid_i) begin
                  instr_q   <= cmd_instr_i;
                  data_q    <= cmd_data_i;
                  cnt_q     <= cnt_clamped;
                  idx_q     <= 3'd0;
                  paddr_o   <= 8'h00;
                  pwdata_o  <= cmd_instr_i;
                  psel_o    <= 1'b1;
                  penable_o <= 1'b0;
                  pwrite_o  <= 1'b1;
                  busy_o    <= 1'b1;
                  state_q   <= S_SETUP;
               end
            end
            S_SETUP: begin
               penable_o <= 1'b1;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: begin
               if (pready_i) begin
                  if (last_entry) begin
                     psel_o    <= 1'b0;
                     penable_o <= 1'b0;
                     pwrite_o  <= 1'b0;
                     paddr_o   <= '0;
                     pwdata_o  <= '0;
                     tmo_q     <= '0;
                     // With no data bytes the master never drops cs, so skip straight to the rise wait.
                     state_q   <= (cnt_q == 3'd0) ? S_WAIT_HIGH : S_WAIT_LOW;
                  end else begin
                     idx_q                 <= idx_q + 3'd1;
                     {paddr_o, pwdata_o}   <= write_entry(idx_q + 3'd1, cnt_q, instr_q, data_q);
                     penable_o             <= 1'b0;
                     state_q               <= S_SETUP;
                  end
               end
            end
            S_WAIT_LOW: begin
               tmo_q <= tmo_q + 16'd1;
               if (tmo_hit) begin
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= S_IDLE;
               end else if (!spi_cs_i) begin
                  state_q <= S_WAIT_HIGH;
               end
            end
            S_WAIT_HIGH: begin
               tmo_q <= tmo_q + 16'd1;
               // A cs rise on the expiry cycle still counts as a normal completion.
               if (spi_cs_i) begin
                  done_o  <= 1'b1;
                  busy_o  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (tmo_hit) begin
                  timeout_o <= 1'b1;
                  busy_o    <= 1'b0;
                  state_q   <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

APB command sequencer that sits directly upstream of the SPI master's APB register port. It accepts one SPI command per valid/ready handshake: an instruction byte plus 0–5 data bytes. It programs the master's INSTR, BYTES_1..5, BYTES_CNT and DRIVE registers with back-to-back APB writes. It then watches the master's chip-select to report completion or timeout.

## Interface
- TIMEOUT_CYCLES, default 1023: maximum cycles spent waiting on chip-select after the DRIVE write (16-bit counter).
- pclk_i  in  1  clock; all logic on rising edge
- presetn_i  in  1  reset presetn_i, asynchronous, active-low; clock pclk_i
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  sequencer idle, command accepted when valid&&ready
- cmd_instr_i  in  8  instruction byte
- cmd_data_i  in  40  data bytes; byte k at [8k+7:8k], k=0..4
- cmd_cnt_i  in  3  number of data bytes; values >5 clamped to 5
- busy_o  out  1  high from acceptance until done/timeout pulse
- done_o  out  1  one-cycle pulse: transfer finished
- timeout_o  out  1  one-cycle pulse: chip-select wait expired
- paddr_o  out  8  APB address
- psel_o, penable_o, pwrite_o  out  1 each  APB control
- pwdata_o  out  8  APB write data
- pready_i  in  1  APB ready from master
- spi_cs_i  in  1  master chip-select, active-low, monitor only

## Operation
- States: IDLE, SETUP, ACCESS, WAIT_LOW, WAIT_HIGH.
- IDLE: cmd_ready_o=1, busy_o=0. On accept, latch instr, data and clamped cnt into the write list, then go to SETUP.
- Write list, in order:
  - 0x00 ← instr
  - 0x01..0x00+cnt ← data bytes 0..cnt-1
  - 0x06 ← cnt
  - 0x07 ← 0xFF
- Total writes = 3+cnt.
- SETUP (1 cycle): psel=1, penable=0, pwrite=1, paddr/pwdata = current entry. Go to ACCESS.
- ACCESS: psel=1, penable=1, address and data held stable. Stay while pready_i=0.
- ACCESS with pready_i=1: the write completes.
  - If entries remain: advance the entry index and go to SETUP next cycle (no idle cycle between writes).
  - After the DRIVE write: go to WAIT_LOW if cnt≥1, WAIT_HIGH if cnt=0. With cnt=0 the master never asserts cs.
- WAIT_LOW: wait for spi_cs_i=0, then go to WAIT_HIGH.
- WAIT_HIGH: on spi_cs_i=1, assert done_o for 1 cycle and return to IDLE.
- Timeout: a 16-bit counter clears on leaving ACCESS and increments every cycle in WAIT_LOW/WAIT_HIGH. When it equals TIMEOUT_CYCLES, timeout_o pulses for 1 cycle instead of done_o, and the FSM returns to IDLE.
- APB outputs in WAIT/IDLE: psel=penable=pwrite=0, paddr=0, pwdata=0.
- cmd_valid_i while busy is ignored; it is not accepted and no state changes.
- spi_cs_i is sampled directly (same clock domain); no synchronizer.

## Timing
- Reset (async, immediate): state IDLE; psel_o, penable_o, pwrite_o, done_o, timeout_o, busy_o = 0; paddr_o, pwdata_o = 0x00; counters 0. cmd_ready_o=1 after reset release.
- Reset mid-transfer aborts at once: APB outputs drop to 0 in the same cycle presetn_i falls; no partial pulse afterwards.
- All outputs are registered except cmd_ready_o, which is decoded from state.
- Accept at edge E: busy_o=1 and the first SETUP are visible after E. cmd_ready_o=0 from E.
- With pready_i tied 1, each write takes 2 cycles. The DRIVE access completes at edge E+2·(3+cnt).
- done_o/timeout_o are asserted in the cycle after the triggering condition is sampled. busy_o falls in the same cycle as the pulse; cmd_ready_o returns 1 in that cycle. A new command can be accepted on that same edge.
- Simultaneous cs rise and timeout expiry in WAIT_HIGH: done_o wins, timeout_o stays 0.

## Test plan
- Reset: hold presetn_i=0 with random inputs → all APB outputs 0, cmd_ready_o=1, no pulses.
- cnt=2, instr=0x9F, data=0x..._BB_AA, pready=1:
  - expected APB writes: (0x00,0x9F), (0x01,0xAA), (0x02,0xBB), (0x06,0x02), (0x07,0xFF), back-to-back, 10 cycles;
  - bench drives cs low for 24 cycles then high → done_o pulses once the cycle after the rise.
- pready_i held low 3 cycles during the BYTES_1 access → paddr/pwdata/psel/penable stable for 4 ACCESS cycles; sequence otherwise unchanged.
- cnt=7 (clamped) → 8 writes with BYTES_CNT=0x05. cnt=0 → 3 writes (0x00, 0x06=0x00, 0x07=0xFF), then done_o with cs held high.
- TIMEOUT_CYCLES=15, cs never falls with cnt=3 → timeout_o pulses exactly 15 cycles after WAIT_LOW entry; no done_o; cmd_ready_o=1 afterwards.
- Assert presetn_i low during the third ACCESS → immediate return to reset values. A new command after release restarts from the INSTR write.
